// File: rtl/sequencer_cpu_ocimem_pkg.sv
// Shared types and debug shift-register field positions for the OCI memory arbiter.
// Also holds the round-robin pick used when the CPU and debug request together.
package sequencer_cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_e;

  localparam int JDO_W           = 38;
  localparam int JDO_RD_BIT      = 35;
  localparam int JDO_CLR_OVR_BIT = 37;
  localparam int JDO_ADDR_LSB    = 17;
  localparam int JDO_DATA_LSB    = 3;

  function automatic grant_e rr_pick(input logic cpu_req, input logic dbg_req, input grant_e last);
    if (cpu_req && dbg_req) return (last == GNT_CPU) ? GNT_DBG : GNT_CPU;
    else if (dbg_req)       return GNT_DBG;
    else                    return GNT_CPU;
  endfunction

endpackage

// File: rtl/sequencer_cpu_ocimem_dbg_cmd.sv
// Debug command decode: one-deep pending op, auto-incrementing address, sticky overrun.
// Commands land one cycle after the pulse; a command while an op is pending (and not completing) is dropped.
module sequencer_cpu_ocimem_dbg_cmd
  import sequencer_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              op_done,
  output logic              pending,
  output logic              pend_rd,
  output logic [31:0]       pend_wdata,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_overrun
);

  logic              pending_q, pending_d;
  logic              pend_rd_q, pend_rd_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovr_q, ovr_d;
  logic              cmd, busy;
  logic              unused_jdo;

  assign cmd        = take_action_ocimem_a | take_action_ocimem_b;
  // Completion frees the slot in the same cycle, so a back-to-back command is not an overrun.
  assign busy       = pending_q & ~op_done;
  assign unused_jdo = ^{jdo[JDO_DATA_LSB-1:0], jdo[36]};

  always_comb begin
    pending_d = pending_q;
    pend_rd_d = pend_rd_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    ovr_d     = ovr_q;
    if (op_done) begin
      pending_d = 1'b0;
      addr_d    = addr_q + ADDR_W'(1);
    end
    if (cmd && !busy) begin
      if (take_action_ocimem_a) begin
        addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_RD_BIT]) begin
          pending_d = 1'b1;
          pend_rd_d = 1'b1;
        end
        if (jdo[JDO_CLR_OVR_BIT]) ovr_d = 1'b0;
      end else begin
        pending_d = 1'b1;
        pend_rd_d = 1'b0;
        wdata_d   = jdo[JDO_DATA_LSB +: 32];
      end
    end else if (cmd) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      pend_rd_q <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pend_rd_q <= pend_rd_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pending     = pending_q;
  assign pend_rd     = pend_rd_q;
  assign pend_wdata  = wdata_q;
  assign dbg_addr    = addr_q;
  assign dbg_overrun = ovr_q;

endmodule

// File: rtl/sequencer_cpu_ocimem_arbiter.sv
// Round-robin arbiter of the OCI RAM between CPU Avalon slave and debug path; CPU reads take 2 cycles, writes 1.
// CPU is stalled via av_waitrequest while not completing; OCIMEM_WRITE_PROTECT_EN adds cpu_wp/wp_violation.
module sequencer_cpu_ocimem_arbiter
  import sequencer_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              dbg_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef OCIMEM_WRITE_PROTECT_EN
  input  logic              cpu_wp,
  output logic              wp_violation,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  if (DATA_W != 32) begin : g_bad_width
    $error("DATA_W must be 32");
  end

  state_e            state_q, state_d;
  grant_e            last_q, last_d, gnt;
  logic [DATA_W-1:0] mon_q, mon_d;
  logic              pending, pend_rd, op_done, grant_vld;
  logic              cpu_wr_fire, dbg_wr_fire, wp_blk;
  logic [31:0]       pend_wdata;
  logic [ADDR_W-1:0] dbg_addr;

  sequencer_cpu_ocimem_dbg_cmd #(.ADDR_W(ADDR_W)) u_dbg_cmd (
    .clk                  (clk),
    .reset                (reset),
    .jdo                  (jdo),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .op_done              (op_done),
    .pending              (pending),
    .pend_rd              (pend_rd),
    .pend_wdata           (pend_wdata),
    .dbg_addr             (dbg_addr),
    .dbg_overrun          (dbg_overrun)
  );

  assign grant_vld = (state_q == IDLE) && (av_read || av_write || pending);
  assign gnt       = rr_pick(av_read | av_write, pending, last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GNT_CPU;
      mon_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      mon_q   <= mon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    mon_d   = mon_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          last_d = gnt;
          if (gnt == GNT_CPU && av_read)      state_d = CPU_RD;
          else if (gnt == GNT_DBG && pend_rd) state_d = DBG_RD;
        end
      end
      CPU_RD:  state_d = IDLE;
      DBG_RD: begin
        state_d = IDLE;
        mon_d   = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    av_waitrequest = 1'b1;
    cpu_wr_fire    = 1'b0;
    dbg_wr_fire    = 1'b0;
    op_done        = 1'b0;
    ram_addr       = av_address;
    ram_byteen     = av_byteenable;
    ram_wdata      = av_writedata;
    case (state_q)
      IDLE: begin
        if (grant_vld && gnt == GNT_CPU) begin
          // Read precedence: a simultaneous write is ignored until the read retires.
          if (!av_read) begin
            av_waitrequest = 1'b0;
            cpu_wr_fire    = 1'b1;
          end
        end else if (grant_vld) begin
          ram_addr   = dbg_addr;
          ram_byteen = 4'hF;
          ram_wdata  = pend_wdata;
          if (!pend_rd) begin
            dbg_wr_fire = 1'b1;
            op_done     = 1'b1;
          end
        end
      end
      CPU_RD: av_waitrequest = 1'b0;
      DBG_RD: begin
        ram_addr = dbg_addr;
        op_done  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      av_waitrequest = 1'b1;
      op_done        = 1'b0;
    end
  end

`ifdef OCIMEM_WRITE_PROTECT_EN
  assign wp_blk       = cpu_wp;
  assign wp_violation = cpu_wr_fire & cpu_wp & ~reset;
`else
  assign wp_blk       = 1'b0;
`endif

  assign ram_wren      = (dbg_wr_fire | (cpu_wr_fire & ~wp_blk)) & ~reset;
  assign av_readdata   = ram_rdata;
  assign MonDReg       = mon_q;
  assign monitor_ready = ~pending;

endmodule

// File: tb/tb_sequencer_cpu_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter: cycle table plus hand-written overrun, contention and reset sequences.
module tb_sequencer_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [37:0] jdo;
  logic        ta_a, ta_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, dbg_overrun;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        mem_init;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  sequencer_cpu_ocimem_arbiter dut (
    .clk(clk), .reset(reset),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .jdo(jdo), .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .dbg_overrun(dbg_overrun),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 32) ? 32'h1234_5678 : 32'h0;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        rst, rd, wr;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic        ta, tb;
    logic [37:0] jdo;
    logic        e_wait, e_wren, chk_addr;
    logic [7:0]  e_raddr;
    logic        e_rdy;
    logic [31:0] e_mon;
    logic        e_ovr;
    logic [31:0] e_rdat;
  } vec_t;

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[35] = rd;
    j[37] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic vec_t mv(input logic rst, rd, wr, input logic [7:0] addr, input logic [31:0] wdat,
                              input logic ta, tb, input logic [37:0] j,
                              input logic e_wait, e_wren, chk_addr, input logic [7:0] e_raddr,
                              input logic e_rdy, input logic [31:0] e_mon, input logic e_ovr,
                              input logic [31:0] e_rdat);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat;
    v.ta = ta; v.tb = tb; v.jdo = j;
    v.e_wait = e_wait; v.e_wren = e_wren; v.chk_addr = chk_addr; v.e_raddr = e_raddr;
    v.e_rdy = e_rdy; v.e_mon = e_mon; v.e_ovr = e_ovr; v.e_rdat = e_rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rd, wr, input logic [7:0] addr, input logic [31:0] wdat,
                       input logic ta, tb, input logic [37:0] j);
    reset = rst; av_read = rd; av_write = wr; av_address = addr; av_writedata = wdat;
    av_byteenable = 4'hF; ta_a = ta; ta_b = tb; jdo = j;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [19];
  int   run, max_run, dbg_cyc, cpu_done;

  initial begin
    mem_init = 1'b1;
    drive(1, 0, 0, 8'h0, 32'h0, 0, 0, '0);
    next_cycle();
    next_cycle();
    mem_init = 1'b0;

    //        rst rd wr addr   wdat          ta tb jdo                       wait wren ca raddr rdy mon            ovr rdat
    vt[0]  = mv(1, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 0, 0, 8'h00, 1, 32'h0,        0, 32'h0);
    vt[1]  = mv(0, 0, 0, 8'h00, 32'h0,        1, 0, mk_a(8'h10, 0, 0),        1, 0, 0, 8'h00, 1, 32'h0,        0, 32'h0);
    vt[2]  = mv(0, 0, 0, 8'h00, 32'h0,        0, 1, mk_b(32'hDEAD_BEEF),      1, 0, 0, 8'h00, 1, 32'h0,        0, 32'h0);
    vt[3]  = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 1, 1, 8'h10, 0, 32'h0,        0, 32'h0);
    vt[4]  = mv(0, 0, 0, 8'h00, 32'h0,        1, 0, mk_a(8'h10, 1, 0),        1, 0, 0, 8'h00, 1, 32'h0,        0, 32'h0);
    vt[5]  = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 0, 1, 8'h10, 0, 32'h0,        0, 32'h0);
    vt[6]  = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 0, 0, 8'h00, 0, 32'h0,        0, 32'h0);
    vt[7]  = mv(0, 1, 0, 8'h20, 32'h0,        0, 0, '0,                       1, 0, 1, 8'h20, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[8]  = mv(0, 1, 0, 8'h20, 32'h0,        0, 0, '0,                       0, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h1234_5678);
    vt[9]  = mv(0, 0, 1, 8'h30, 32'hCAFE_F00D, 0, 0, '0,                      0, 1, 1, 8'h30, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[10] = mv(0, 0, 0, 8'h00, 32'h0,        1, 0, mk_a(8'hFF, 0, 0),        1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[11] = mv(0, 0, 0, 8'h00, 32'h0,        0, 1, mk_b(32'h1),              1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[12] = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 1, 1, 8'hFF, 0, 32'hDEAD_BEEF, 0, 32'h0);
    vt[13] = mv(0, 0, 0, 8'h00, 32'h0,        0, 1, mk_b(32'h2),              1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[14] = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 1, 1, 8'h00, 0, 32'hDEAD_BEEF, 0, 32'h0);
    vt[15] = mv(0, 0, 0, 8'h00, 32'h0,        1, 1, mk_a(8'h40, 0, 0),        1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[16] = mv(0, 0, 0, 8'h00, 32'h0,        0, 1, mk_b(32'h55),             1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);
    vt[17] = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 1, 1, 8'h40, 0, 32'hDEAD_BEEF, 0, 32'h0);
    vt[18] = mv(0, 0, 0, 8'h00, 32'h0,        0, 0, '0,                       1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF, 0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdat, vt[i].ta, vt[i].tb, vt[i].jdo);
      #1;
      chk($sformatf("row%0d waitrequest", i), 32'(av_waitrequest), 32'(vt[i].e_wait));
      chk($sformatf("row%0d ram_wren", i), 32'(ram_wren), 32'(vt[i].e_wren));
      chk($sformatf("row%0d monitor_ready", i), 32'(monitor_ready), 32'(vt[i].e_rdy));
      chk($sformatf("row%0d MonDReg", i), MonDReg, vt[i].e_mon);
      chk($sformatf("row%0d dbg_overrun", i), 32'(dbg_overrun), 32'(vt[i].e_ovr));
      if (vt[i].chk_addr) chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].e_raddr));
      if (vt[i].rd && !vt[i].e_wait) chk($sformatf("row%0d readdata", i), av_readdata, vt[i].e_rdat);
      next_cycle();
    end
    chk("mem dbg write 0x10", mem[8'h10], 32'hDEAD_BEEF);
    chk("mem wrap 0xFF", mem[8'hFF], 32'h1);
    chk("mem wrap 0x00", mem[8'h00], 32'h2);
    chk("mem cpu write 0x30", mem[8'h30], 32'hCAFE_F00D);
    chk("mem a+b addr 0x40", mem[8'h40], 32'h55);

    // Overrun: second write arrives while the first waits behind a CPU read.
    drive(0, 0, 0, 8'h00, 32'h0, 1, 0, mk_a(8'h50, 0, 0)); next_cycle();
    drive(0, 1, 0, 8'h20, 32'h0, 0, 1, mk_b(32'h77)); #1;
    chk("ovr cpu granted stall", 32'(av_waitrequest), 32'h1);
    next_cycle();
    drive(0, 1, 0, 8'h20, 32'h0, 0, 1, mk_b(32'h88)); #1;
    chk("ovr cpu completes", 32'(av_waitrequest), 32'h0);
    chk("ovr pending busy", 32'(monitor_ready), 32'h0);
    next_cycle();
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, '0); #1;
    chk("ovr sticky set", 32'(dbg_overrun), 32'h1);
    chk("ovr first write wren", 32'(ram_wren), 32'h1);
    chk("ovr first write addr", 32'(ram_addr), 32'h50);
    next_cycle();
    drive(0, 0, 0, 8'h00, 32'h0, 1, 0, mk_a(8'h60, 0, 1)); #1;
    chk("ovr still set", 32'(dbg_overrun), 32'h1);
    next_cycle();
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, '0); #1;
    chk("ovr cleared", 32'(dbg_overrun), 32'h0);
    chk("ovr mem first", mem[8'h50], 32'h77);
    chk("ovr mem dropped", mem[8'h51], 32'h0);

    // Contention: CPU reads back to back while one debug write is queued.
    run = 0; max_run = 0; dbg_cyc = -1; cpu_done = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, 0, 8'h20, 32'h0, 0, (c == 0), mk_b(32'h0000_ABCD)); #1;
      if (ram_wren && ram_addr == 8'h60 && dbg_cyc < 0) dbg_cyc = c;
      if (av_waitrequest) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        cpu_done++;
        chk($sformatf("cont readdata c%0d", c), av_readdata, 32'h1234_5678);
      end
      next_cycle();
    end
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, '0); next_cycle(); next_cycle();
    chk("cont dbg write seen", 32'(dbg_cyc >= 0), 32'h1);
    chk("cont dbg within 3", 32'(dbg_cyc <= 3), 32'h1);
    chk("cont max cpu stall", 32'(max_run), 32'h2);
    chk("cont cpu completions", 32'(cpu_done), 32'h5);
    chk("cont mem", mem[8'h60], 32'h0000_ABCD);

    // Reset in CPU_RD with a debug write queued.
    drive(0, 1, 0, 8'h20, 32'h0, 0, 1, mk_b(32'h99)); #1;
    chk("rst pre stall", 32'(av_waitrequest), 32'h1);
    next_cycle();
    drive(1, 1, 0, 8'h20, 32'h0, 0, 0, '0); #1;
    chk("rst forces wait", 32'(av_waitrequest), 32'h1);
    chk("rst no wren", 32'(ram_wren), 32'h0);
    next_cycle();
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, '0); #1;
    chk("rst after wait", 32'(av_waitrequest), 32'h1);
    chk("rst after MonDReg", MonDReg, 32'h0);
    chk("rst after ready", 32'(monitor_ready), 32'h1);
    chk("rst after wren", 32'(ram_wren), 32'h0);
    next_cycle(); #1;
    chk("rst idle wren", 32'(ram_wren), 32'h0);
    next_cycle();
    chk("rst no stale write 0x00", mem[8'h00], 32'h2);
    chk("rst no stale write 0x61", mem[8'h61], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequencer_cpu_ocimem_arbiter.md
Name: sequencer_cpu_ocimem_arbiter

Overview:
Arbitrates the sequencer CPU's single-port on-chip monitor RAM (OCI memory) between two requesters. One is the CPU Avalon-MM slave port. The other is the JTAG debug path's system-clock-side command pulses (take_action_ocimem_a/b with jdo). The block sequences debug reads and writes with address auto-increment, returns debug read data in MonDReg, and reports monitor_ready back to the debug tck-side logic.

Parameters:
ADDR_W, 8, word address width of OCI RAM (2^ADDR_W 32-bit words)
DATA_W, 32, data width; fixed at 32, checked by elaboration assertion

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
av_address  in  ADDR_W  CPU word address
av_read  in  1  CPU read request, held until waitrequest low
av_write  in  1  CPU write request, held until waitrequest low
av_writedata  in  32  CPU write data
av_byteenable  in  4  CPU byte enables
av_readdata  out  32  CPU read data, valid when av_read and !av_waitrequest
av_waitrequest  out  1  CPU stall
jdo  in  38  debug shift-register contents
take_action_ocimem_a  in  1  debug address/command pulse
take_action_ocimem_b  in  1  debug data-write pulse
MonDReg  out  32  last debug read data
monitor_ready  out  1  no debug operation pending
dbg_overrun  out  1  sticky: debug command dropped
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, 1-cycle latency

Behaviour:
- Reset (sync, high): state IDLE, debug pending cleared, dbg_addr=0, MonDReg=0, monitor_ready=1, dbg_overrun=0, last_grant=CPU, ram_wren=0. av_waitrequest forced 1 while reset is high. An in-flight access is abandoned and no completion is signalled.
- take_action_ocimem_a:
  - dbg_addr <= jdo[ADDR_W+16:17].
  - If jdo[35]=1, queue a debug read.
  - If jdo[37]=1, clear dbg_overrun.
- take_action_ocimem_b: queue a debug write of jdo[34:3] to dbg_addr with all byte enables set.
- a and b in the same cycle: a wins, b is ignored, dbg_overrun is not set.
- Pending register is one deep. A command arriving while a debug op is pending is dropped and sets dbg_overrun. monitor_ready = !pending.
- FSM states IDLE, CPU_RD, DBG_RD:
  - IDLE, only CPU pending: grant CPU.
  - IDLE, only debug pending: grant debug.
  - IDLE, both pending: grant the requester not in last_grant (round robin); last_grant updates on every grant.
  - CPU write granted in IDLE: ram_wren=1 with av address/data/byteenable; av_waitrequest=0 in the same cycle; stay IDLE.
  - CPU read granted in IDLE: drive ram_addr, go to CPU_RD. In CPU_RD: av_readdata=ram_rdata, av_waitrequest=0, go to IDLE. Read latency is 2 cycles.
  - Debug write granted: ram_wren=1, clear pending, dbg_addr+1, stay IDLE.
  - Debug read granted: go to DBG_RD. In DBG_RD: MonDReg<=ram_rdata, clear pending, dbg_addr+1, go to IDLE.
- dbg_addr increments modulo 2^ADDR_W: all-ones wraps to 0.
- A debug command arriving in the same cycle the previous one completes is accepted, not an overrun.
- av_waitrequest=1 whenever the CPU is not completing. av_read and av_write asserted together is illegal; read takes precedence.

Optional Feature:
OCIMEM_WRITE_PROTECT_EN.
- With macro: adds input cpu_wp (1) and output wp_violation (1).
  - CPU write while cpu_wp=1: completes normally (waitrequest low) but ram_wren stays 0, and wp_violation pulses 1 cycle.
  - Debug writes are never protected.
- Without macro: ports absent, all CPU writes reach RAM.

Decomposition:
- Package sequencer_cpu_ocimem_pkg: state enum (IDLE, CPU_RD, DBG_RD), grant enum, jdo field constants (JDO_RD_BIT=35, JDO_CLR_OVR_BIT=37, JDO_ADDR_LSB=17, JDO_DATA_LSB=3).
- One sub-module, sequencer_cpu_ocimem_dbg_cmd: decodes take_action pulses, holds the pending register, dbg_addr, and the overrun logic.

Test Plan:
- Debug write then read back:
  - Stimulus: a(addr=0x10, rd=0); b(data=0xDEADBEEF); a(addr=0x10, rd=1).
  - Response: RAM[0x10]=0xDEADBEEF; MonDReg=0xDEADBEEF 2 cycles after the last pulse; monitor_ready low then high.
- Auto-increment wrap:
  - Stimulus: a(addr=0xFF); b(data=1); b(data=2).
  - Response: RAM[0xFF]=1, RAM[0x00]=2.
- CPU read latency:
  - Stimulus: CPU read of 0x20 holding 0x12345678.
  - Response: waitrequest high for 1 cycle, low in cycle 2 with readdata=0x12345678.
- Contention:
  - Stimulus: continuous CPU reads plus a debug write pending.
  - Response: grants alternate; the debug write completes within 3 cycles; the CPU is never stalled more than 3 cycles.
- Overrun:
  - Stimulus: b pulse while CPU_RD holds arbitration and a debug op is already pending.
  - Response: dbg_overrun=1; the second write is absent from RAM; a(jdo[37]=1) clears it.
- Reset mid-read:
  - Stimulus: assert reset in CPU_RD.
  - Response: next cycle state IDLE, waitrequest=1, MonDReg=0, monitor_ready=1, no ram_wren.
